// File: rtl/rv32i_pkg.sv
// Shared RV32I encoder definitions: opcode values, the NOP word, loader FSM
// states and the decoded field bundle that the loader presents to the encoder.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // func = {funct7[5], funct3}
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  func;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: decoded field bundle -> 32-bit instruction word.
// Unknown opcodes produce NOP with err=1.
// Build option: IMM_CHECK_EN adds immediate range checks (violation -> NOP, err=1);
// without it excess immediate bits are silently truncated.
// Ports:
//   f    in   field bundle
//   inst out  encoded word
//   err  out  word was replaced by NOP
module inst_pack
  import rv32i_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] inst,
  output logic        err
);

  logic [2:0]  f3;
  logic        f7b;
  logic [31:0] imm;

  assign f3  = f.func[2:0];
  assign f7b = f.func[3];
  assign imm = f.imm;

`ifdef IMM_CHECK_EN
  logic sext12, sext13_even, sext21_even, u_clean, imm_bad;
  // upper bits must all replicate the sign bit of the encodable field
  assign sext12      = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext13_even = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign sext21_even = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_clean     = ~(|imm[11:0]);
`endif

  always_comb begin
    inst = NOP;
    err  = 1'b0;
`ifdef IMM_CHECK_EN
    imm_bad = 1'b0;
`endif
    case (f.opcode)
      OP_R: inst = {1'b0, f7b, 5'b0, f.rs2, f.rs1, f3, f.rd, f.opcode};
      OP_IMM: begin
        // slli/srli/srai carry shamt in imm[4:0] and the arithmetic bit in f7b
        if (f3 == 3'b001 || f3 == 3'b101)
          inst = {1'b0, f7b, 5'b0, imm[4:0], f.rs1, f3, f.rd, f.opcode};
        else
          inst = {imm[11:0], f.rs1, f3, f.rd, f.opcode};
`ifdef IMM_CHECK_EN
        imm_bad = ~sext12;
`endif
      end
      OP_LOAD, OP_JALR: begin
        inst = {imm[11:0], f.rs1, f3, f.rd, f.opcode};
`ifdef IMM_CHECK_EN
        imm_bad = ~sext12;
`endif
      end
      OP_STORE: begin
        inst = {imm[11:5], f.rs2, f.rs1, f3, imm[4:0], f.opcode};
`ifdef IMM_CHECK_EN
        imm_bad = ~sext12;
`endif
      end
      OP_BRANCH: begin
        inst = {imm[12], imm[10:5], f.rs2, f.rs1, f3, imm[4:1], imm[11], f.opcode};
`ifdef IMM_CHECK_EN
        imm_bad = ~sext13_even;
`endif
      end
      OP_JAL: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
`ifdef IMM_CHECK_EN
        imm_bad = ~sext21_even;
`endif
      end
      OP_LUI, OP_AUIPC: begin
        inst = {imm[31:12], f.rd, f.opcode};
`ifdef IMM_CHECK_EN
        imm_bad = ~u_clean;
`endif
      end
      default: err = 1'b1;
    endcase
`ifdef IMM_CHECK_EN
    if (imm_bad) begin
      inst = NOP;
      err  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I program loader: accepts decoded field bundles, packs them into
// instruction words and writes them with incrementing byte addresses to IMEM
// through a single output register. Build option: IMM_CHECK_EN (see inst_pack).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a new program load (honoured only when idle)
//   in_valid/in_ready     input bundle handshake; in_last marks the final bundle
//   in_opcode..in_imm     decoded fields
//   out_valid/out_ready   output word handshake
//   out_inst/out_addr     encoded word and its byte address
//   out_err               word was replaced by NOP
//   done                  one-cycle pulse once the last word has been taken
//   count                 words written since start
module inst_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [6:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [3:0]    in_func,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_inst,
  output logic [AW-1:0] out_addr,
  output logic          out_err,
  output logic          done,
  output logic [AW-1:0] count
);

  state_t        state;
  logic [AW-1:0] next_addr;
  fields_t       fields;
  logic [31:0]   pk_inst;
  logic          pk_err;
  logic          accept;
  logic          out_hs;

  assign fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    func: in_func, imm: in_imm};

  inst_pack u_pack (
    .f    (fields),
    .inst (pk_inst),
    .err  (pk_err)
  );

  // Output register may be refilled on the same edge it is drained.
  assign in_ready = (state == ST_RUN) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  // Loader FSM, output register and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_addr  <= AW'(BASE_ADDR);
      out_err   <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      next_addr <= AW'(BASE_ADDR);
    end else begin
      done <= 1'b0;
      if (out_hs) begin
        out_valid <= 1'b0;
        count     <= count + AW'(1);
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_inst  <= pk_inst;
        out_err   <= pk_err;
        out_addr  <= next_addr;
        next_addr <= next_addr + AW'(4);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            next_addr <= AW'(BASE_ADDR);
            count     <= '0;
          end
        end
        ST_RUN: begin
          if (accept && in_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // register is empty once this edge has drained it
          if (~out_valid | out_ready) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encodings, a stalled 3-word
// stream, random programs with random back-pressure, address wrap and
// mid-load reset, all checked against a field-arithmetic reference model.
module tb_inst_encoder;

  localparam int unsigned AW   = 10;
  localparam int unsigned BASE = 0;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_last;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [3:0]    in_func;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready, out_err, done;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr, count;

  inst_encoder #(.AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func(in_func), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  func;
    logic [31:0] imm;
    logic [31:0] xinst;
    logic        xerr;
  } bundle_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } oword_t;

  int n_cmp = 0;
  int n_bad = 0;

  oword_t      exp_q[$];
  bit          run_active = 0;
  bit          in_prog = 0;
  int unsigned next_addr = BASE;
  int unsigned cnt = 0;
  int          done_cnt = 0;
  bundle_t     blank = '{7'h0, 5'h0, 5'h0, 5'h0, 4'h0, 32'h0, 32'h0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef IMM_CHECK_EN
  function automatic bit sfits(input int unsigned v, input int bits);
    int s;
    s = int'(v);
    return (s >= -(1 <<< (bits - 1))) && (s < (1 <<< (bits - 1)));
  endfunction
`endif

  // Reference encoder: place each field by shift-and-mask arithmetic.
  function automatic void model(input bundle_t b, output logic [31:0] inst, output logic err);
    int unsigned op, rd, rs1, rs2, f3, f7, imm, w;
    bit known, range_ok;
    op = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm = b.imm;
    f3 = b.func & 7; f7 = (b.func >> 3) & 1;
    known = 1; range_ok = 1; w = 0;
    case (op)
      'h33: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      'h13, 'h03, 'h67: begin
        if (op == 'h13 && (f3 == 1 || f3 == 5))
          w = (f7 << 30) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        else
          w = ((imm & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
`ifdef IMM_CHECK_EN
        range_ok = sfits(imm, 12);
`endif
      end
      'h23: begin
        w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 31) << 7) | op;
`ifdef IMM_CHECK_EN
        range_ok = sfits(imm, 12);
`endif
      end
      'h63: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
          | (((imm >> 11) & 1) << 7) | op;
`ifdef IMM_CHECK_EN
        range_ok = sfits(imm, 13) && (imm % 2 == 0);
`endif
      end
      'h6F: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
`ifdef IMM_CHECK_EN
        range_ok = sfits(imm, 21) && (imm % 2 == 0);
`endif
      end
      'h37, 'h17: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
`ifdef IMM_CHECK_EN
        range_ok = (imm % 4096 == 0);
`endif
      end
      default: known = 0;
    endcase
    if (!known || !range_ok) begin
      inst = 32'h0000_0013;
      err  = 1'b1;
    end else begin
      inst = w;
      err  = 1'b0;
    end
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    b.op   = ($urandom % 8 == 0) ? 7'($urandom) : ops[$urandom % 9];
    b.rd   = 5'($urandom);
    b.rs1  = 5'($urandom);
    b.rs2  = 5'($urandom);
    b.func = 4'($urandom);
    b.imm  = ($urandom % 2 == 0) ? 32'(int'($urandom_range(6000)) - 3000) : 32'($urandom);
    model(b, b.xinst, b.xerr);
    return b;
  endfunction

  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [3:0] func,
                                 input logic [31:0] imm, input logic [31:0] xi, input logic xe);
    bundle_t b;
    b = '{op, rd, rs1, rs2, func, imm, xi, xe};
    return b;
  endfunction

  // One clock: drive inputs, check in_ready, advance, update model, check outputs.
  task automatic step(input bit st, input bit iv, input bundle_t b, input bit last,
                      input bit ordy, output bit acc);
    bit exp_rdy, hs;
    start = st; in_valid = iv; in_last = last; out_ready = ordy;
    in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
    in_func = b.func; in_imm = b.imm;
    #1;
    exp_rdy = run_active && (exp_q.size() == 0 || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    hs  = (exp_q.size() != 0) && ordy;
    @(posedge clk); #1;
    if (hs) begin
      exp_q.delete(0);
      cnt++;
    end
    if (acc) begin
      exp_q.push_back('{b.xinst, next_addr % (1 << AW), b.xerr});
      next_addr += 4;
      if (last) run_active = 0;
    end
    if (st && !in_prog) begin
      in_prog = 1; run_active = 1; next_addr = BASE; cnt = 0;
    end
    if (done) begin
      done_cnt++;
      in_prog = 0;
      check("count_at_done", 32'(count), cnt % (1 << AW));
    end
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_inst", out_inst, exp_q[0].inst);
      check("out_addr", 32'(out_addr), exp_q[0].addr);
      check("out_err", 32'(out_err), 32'(exp_q[0].err));
    end
    check("count", 32'(count), cnt % (1 << AW));
    start = 1'b0;
  endtask

  task automatic run_program(input bundle_t prog[$], input int rdy_pct, input int vld_pct,
                             input bit mid_start, input int stall_idx);
    bit acc, iv, ordy, st;
    int sent, cyc, stall_left, n, bound, k;
    n = prog.size(); sent = 0; cyc = 0; stall_left = 4; bound = n * 30 + 50;
    done_cnt = 0;
    step(1'b1, 1'b0, blank, 1'b0, 1'b1, acc);
    while ((sent < n || exp_q.size() != 0) && cyc < bound) begin
      iv   = (sent < n) && (int'($urandom % 100) < vld_pct);
      ordy = int'($urandom % 100) < rdy_pct;
      if (exp_q.size() != 0 && int'(cnt) == stall_idx && stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      st = mid_start && ($urandom % 8 == 0);
      step(st, iv, (sent < n) ? prog[sent] : blank, sent == n - 1, ordy, acc);
      if (acc) sent++;
      cyc++;
    end
    check("drain_in_budget", 32'(cyc < bound), 32'd1);
    k = 0;
    while (done_cnt == 0 && k < 8) begin
      step(1'b0, 1'b0, blank, 1'b0, 1'b1, acc);
      k++;
    end
    repeat (2) step(1'b0, 1'b0, blank, 1'b0, 1'b1, acc);
    check("done_once", 32'(done_cnt), 32'd1);
    check("words_written", 32'(cnt), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bundle_t prog[$];
    bundle_t b;
    bit acc;
    reset = 1; start = 0; in_valid = 0; in_last = 0; out_ready = 0;
    in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_func = 0; in_imm = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", 32'(out_addr), BASE);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 0;
    step(1'b0, 1'b0, blank, 1'b0, 1'b1, acc);

    // known encodings
    prog.delete();
    prog.push_back(mk(7'h33, 5'd3, 5'd1, 5'd2, 4'b0000, 32'd0, 32'h0020_81B3, 1'b0));
    prog.push_back(mk(7'h33, 5'd3, 5'd1, 5'd2, 4'b1000, 32'd0, 32'h4020_81B3, 1'b0));
    prog.push_back(mk(7'h13, 5'd5, 5'd0, 5'd0, 4'b0000, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0));
    prog.push_back(mk(7'h23, 5'd0, 5'd1, 5'd2, 4'b0010, 32'd8, 32'h0020_A423, 1'b0));
    prog.push_back(mk(7'h63, 5'd0, 5'd1, 5'd2, 4'b0000, 32'd8, 32'h0020_8463, 1'b0));
    prog.push_back(mk(7'h37, 5'd5, 5'd0, 5'd0, 4'b0000, 32'h1234_5000, 32'h1234_52B7, 1'b0));
    prog.push_back(mk(7'h7F, 5'd7, 5'd3, 5'd4, 4'b0101, 32'h55, 32'h0000_0013, 1'b1));
`ifdef IMM_CHECK_EN
    prog.push_back(mk(7'h13, 5'd0, 5'd0, 5'd0, 4'b0000, 32'd2048, 32'h0000_0013, 1'b1));
`else
    prog.push_back(mk(7'h13, 5'd0, 5'd0, 5'd0, 4'b0000, 32'd2048, 32'h8000_0013, 1'b0));
`endif
    run_program(prog, 100, 100, 1'b0, -1);

    // 3-word stream with the second word stalled 4 cycles
    prog.delete();
    repeat (3) prog.push_back(rand_bundle());
    run_program(prog, 100, 100, 1'b0, 1);

    // random programs, random back-pressure, stray start pulses mid-load
    repeat (4) begin
      prog.delete();
      repeat (1 + $urandom % 40) prog.push_back(rand_bundle());
      run_program(prog, 60, 75, 1'b1, -1);
    end

    // long stream at full throughput: address wraps modulo 2^AW
    prog.delete();
    repeat (270) prog.push_back(rand_bundle());
    run_program(prog, 100, 100, 1'b0, -1);

    // reset while a word is held in the output register
    done_cnt = 0;
    step(1'b1, 1'b0, blank, 1'b0, 1'b1, acc);
    b = rand_bundle();
    step(1'b0, 1'b1, b, 1'b0, 1'b0, acc);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    in_valid = 0; out_ready = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete(); run_active = 0; in_prog = 0; cnt = 0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_addr", 32'(out_addr), BASE);
    repeat (5) step(1'b0, 1'b0, blank, 1'b0, 1'b1, acc);
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);

    // loader recovers after the reset
    prog.delete();
    repeat (5) prog.push_back(rand_bundle());
    run_program(prog, 80, 90, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
